// File: rtl/updown_counter_param.sv
// updown_counter_param: parameterised up/down counter with modulus, parallel
// load, synchronous clear, wrap/saturate and a registered terminal-count pulse.
// Optional prescaler: define UPDOWN_COUNTER_PRESCALE_EN to add PRESCALE; the
// main count then steps once per PRESCALE enabled cycles.
module updown_counter_param #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
    parameter bit               SATURATE    = 1'b0,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    parameter int               PRESCALE    = 4,
`endif
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] count_out,
    output logic             terminal_count
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // Prescaler is at least one bit wide so PRESCALE=1 still elaborates;
    // with PRESCALE=1 the terminal phase is always 0 and every cycle steps.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          pre_last;

    assign pre_last = (pre_q == PW'(PRESCALE - 1));
    assign step     = enable && pre_last;

    // Prescaler phase: restarts on clear/load, advances only on enabled cycles.
    always_comb begin
        pre_d = pre_q;
        if (clear || load) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = pre_last ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = enable;
`endif

    // Next count and terminal-count: clear > load > step > hold.
    // Boundaries use explicit compares so non-power-of-two moduli wrap right.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end else if (step) begin
            if (up_down) begin
                if (count_q >= MAX_COUNT) begin
                    count_d = SATURATE ? MAX_COUNT : '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = SATURATE ? '0 : MAX_COUNT;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Count and pulse registers; reset abandons any in-flight pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VALUE;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_out      = count_q;
    assign terminal_count = tc_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four differently configured instances share
// one stimulus stream; a modular-arithmetic reference model predicts each.
module tb_updown_counter_param;

    logic       clock, reset, enable, up_down, load, clear;
    logic [7:0] load_value;

    logic [7:0] c0, c3;
    logic [3:0] c1, c2;
    logic       t0, t1, t2, t3;

    updown_counter_param #(.WIDTH(8)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .count_out(c0), .terminal_count(t0));

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value[3:0]), .clear(clear),
        .count_out(c1), .terminal_count(t1));

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value[3:0]), .clear(clear),
        .count_out(c2), .terminal_count(t2));

    updown_counter_param #(.WIDTH(8), .MAX_COUNT(8'h25), .SATURATE(1'b1),
                           .RESET_VALUE(8'h05)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .clear(clear),
        .count_out(c3), .terminal_count(t3));

    logic [31:0] oc[4];
    logic        ot[4];
    assign oc[0] = 32'(c0);
    assign oc[1] = 32'(c1);
    assign oc[2] = 32'(c2);
    assign oc[3] = 32'(c3);
    assign ot[0] = t0;
    assign ot[1] = t1;
    assign ot[2] = t2;
    assign ot[3] = t3;

    // Reference configuration per instance.
    int mx[4] = '{255, 9, 9, 'h25};
    int st[4] = '{0, 0, 1, 1};
    int rv[4] = '{0, 0, 0, 5};
    int wd[4] = '{8, 4, 4, 8};
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    int cnt[4];
    int tcm[4];
    int pre[4];

    int n_vec = 0;
    int n_err = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.u%0d.count", tag, i), oc[i], 32'(cnt[i]));
            chk($sformatf("%s.u%0d.tc", tag, i), 32'(ot[i]), 32'(tcm[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = rv[i];
            tcm[i] = 0;
            pre[i] = 0;
        end
    endtask

    // Spec rules as plain modular arithmetic over 0..max.
    task automatic model_step();
        int lv, m;
        for (int i = 0; i < 4; i++) begin
            m      = mx[i] + 1;
            tcm[i] = 0;
            if (clear) begin
                cnt[i] = 0;
                pre[i] = 0;
            end else if (load) begin
                lv     = int'(load_value) % (1 << wd[i]);
                cnt[i] = (lv > mx[i]) ? mx[i] : lv;
                pre[i] = 0;
            end else if (enable) begin
                pre[i] = pre[i] + 1;
                if (pre[i] == PS) begin
                    pre[i] = 0;
                    if (up_down) begin
                        tcm[i] = (cnt[i] == mx[i]) ? 1 : 0;
                        cnt[i] = (tcm[i] == 1 && st[i] == 1) ? mx[i] : (cnt[i] + 1) % m;
                    end else begin
                        tcm[i] = (cnt[i] == 0) ? 1 : 0;
                        cnt[i] = (tcm[i] == 1 && st[i] == 1) ? 0 : (cnt[i] + m - 1) % m;
                    end
                end
            end
        end
    endtask

    // One clock: inputs already set; check 1 ns after the edge, return at negedge.
    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
        @(negedge clock);
    endtask

    task automatic set_in(input logic en, input logic ud, input logic ld,
                          input logic cl, input logic [7:0] lv);
        enable = en; up_down = ud; load = ld; clear = cl; load_value = lv;
    endtask

    // Reset pulse between edges (called at a negedge).
    task automatic mid_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 8'h00);
        model_reset();

        // Asynchronous reset visible before the first clock edge.
        #1 reset = 1'b0;
        #2;
        check_all("reset_async");
        #8 reset = 1'b1;

        // Drop-in down-counter behaviour from 0.
        set_in(1, 0, 0, 0, 8'h00);
        repeat (3) cycle("down3");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        chk("down3_lit", 32'(c0), 32'hFD);
`endif

        // Modulus-10 up count: wrap vs saturate.
        set_in(0, 1, 0, 1, 8'h00);
        cycle("clr");
        set_in(1, 1, 0, 0, 8'h00);
        repeat (12) cycle("mod10_up");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        chk("wrap_lit", 32'(c1), 32'd2);
        chk("sat_lit", 32'(c2), 32'd9);
`endif

        // Saturate at max, then step back down.
        set_in(0, 1, 1, 0, 8'h08);
        cycle("ld8");
        set_in(1, 1, 0, 0, 8'h00);
        repeat (4 * PS) cycle("sat_hold");
        set_in(1, 0, 0, 0, 8'h00);
        repeat (PS) cycle("sat_down");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        chk("sat_down_lit", 32'(c2), 32'd8);
        chk("sat_down_tc", 32'(t2), 32'd0);
`endif

        // Priority: clear beats load and enable; then load; then clamp.
        set_in(1, 1, 1, 1, 8'h20);
        cycle("prio_all");
        chk("prio_lit", 32'(c3), 32'h00);
        set_in(1, 1, 1, 0, 8'h20);
        cycle("prio_load");
        chk("load_lit", 32'(c3), 32'h20);
        set_in(0, 1, 1, 0, 8'h30);
        cycle("clamp");
        chk("clamp_lit", 32'(c3), 32'h25);

        // Reset mid-count abandons the count; counting resumes from reset value.
        set_in(0, 1, 1, 0, 8'h3E);
        cycle("ld3e");
        set_in(1, 1, 0, 0, 8'h00);
        repeat (2 * PS) cycle("to40");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        chk("at40_lit", 32'(c0), 32'h40);
`endif
        mid_reset("mid_rst");
        chk("mid_rst_lit", 32'(c3), 32'h05);
        repeat (3) cycle("post_rst");

`ifdef UPDOWN_COUNTER_PRESCALE_EN
        // Prescaled count: steps on enabled cycles 4, 8, 12; load restarts phase.
        set_in(0, 1, 0, 1, 8'h00);
        cycle("ps_clr");
        set_in(1, 1, 0, 0, 8'h00);
        repeat (12) cycle("ps_up");
        chk("ps_lit", 32'(c0), 32'd3);
        repeat (2) cycle("ps_part");
        set_in(0, 1, 1, 0, 8'h00);
        cycle("ps_load");
        set_in(1, 1, 0, 0, 8'h00);
        repeat (4) cycle("ps_rephase");
        chk("ps_rephase_lit", 32'(c0), 32'd1);
`endif

        // Randomised traffic with occasional mid-cycle resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) mid_reset("rnd_rst");
            set_in($urandom_range(0, 9) < 8,
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 29) == 0,
                   8'($urandom));
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
